// File: rtl/pipelined_shifter.sv
// pipelined_shifter: fully pipelined SLL/SRL/SRA/ROR barrel shifter with valid/ready handshake and sideband tag
//
// Ports:
//   clock      rising-edge clock
//   reset_n    synchronous active-low reset
//   in_valid   request present
//   in_ready   request accepted this cycle (depends combinationally on out_ready)
//   in_data    operand
//   in_amt     shift amount 0..WIDTH-1
//   in_mode    00 SLL, 01 SRL, 10 SRA, 11 ROR
//   in_tag     opaque sideband returned with the result
//   out_valid  result present
//   out_ready  consumer accepts result
//   out_data   shifted result
//   out_tag    tag of the request that produced out_data
//   busy       any stage holds a valid entry
module pipelined_shifter #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 5,
    localparam int SHW = $clog2(WIDTH)
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SHW-1:0]   in_amt,
    input  logic [1:0]       in_mode,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
);
    logic [SHW-1:0]             v_q, v_d, adv, en, ld, src_v;
    logic [SHW-1:0][WIDTH-1:0]  data_q, data_d, src_d;
    logic [SHW-1:0][SHW-1:0]    amt_q, src_amt;
    logic [SHW-1:0][1:0]        mode_q, src_mode;
    logic [SHW-1:0][TAG_W-1:0]  tag_q, src_tag;
    logic                       unused_stage_bits;

    // One fixed-distance shift; s is a per-stage constant (2^k) after unrolling.
    function automatic logic [WIDTH-1:0] step_fn(input logic [WIDTH-1:0] d, input logic [1:0] m, input int s);
        return m == 2'd0 ? d << s :
               m == 2'd1 ? d >> s :
               m == 2'd2 ? $unsigned($signed(d) >>> s) :
                           (d >> s) | (d << (WIDTH - s));
    endfunction

    always_comb begin
        adv = '0;
        data_d = '0;
        // Advance chain runs from the output back so bubbles collapse under a stall.
        adv[SHW-1] = v_q[SHW-1] & out_ready;
        for (int k = SHW - 2; k >= 0; k--) adv[k] = v_q[k] & (!v_q[k+1] | adv[k+1]);
        en = ~v_q | adv;
        src_v = {v_q[SHW-2:0], in_valid};
        src_d = {data_q[SHW-2:0], in_data};
        src_amt = {amt_q[SHW-2:0], in_amt};
        src_mode = {mode_q[SHW-2:0], in_mode};
        src_tag = {tag_q[SHW-2:0], in_tag};
        // Data only loads with a valid entry so an emptied stage keeps its last data.
        ld = en & src_v;
        v_d = (v_q & ~en) | ld;
        for (int k = 0; k < SHW; k++) data_d[k] = src_amt[k][k] ? step_fn(src_d[k], src_mode[k], 1 << k) : src_d[k];
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            v_q <= '0;
            data_q <= '0;
            amt_q <= '0;
            mode_q <= '0;
            tag_q <= '0;
        end else begin
            v_q <= v_d;
            for (int k = 0; k < SHW; k++) begin
                if (ld[k]) begin
                    data_q[k] <= data_d[k];
                    amt_q[k] <= src_amt[k];
                    mode_q[k] <= src_mode[k];
                    tag_q[k] <= src_tag[k];
                end
            end
        end
    end

    // Already-consumed amount bits and the last stage's amount/mode are never read downstream.
    assign unused_stage_bits = ^{amt_q, mode_q};

    assign in_ready = en[0];
    assign out_valid = v_q[SHW-1];
    assign out_data = data_q[SHW-1];
    assign out_tag = tag_q[SHW-1];
    assign busy = |v_q;
endmodule
